instr_boot_loader: RTL and testbench
====================================

INSTR_BOOT_LOADER -- requirements
Module: instr_boot_loader

Interface
REQ-001 Parameter: DEPTH, 64, number of 32-bit instruction-memory words.
REQ-002 Parameter: ADDR_W, 6, instruction-memory address width, equal to clog2(DEPTH).
REQ-003 Port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: rx_data  input  8  incoming program byte.
REQ-006 Port: rx_valid  input  1  rx_data is valid this cycle.
REQ-007 Port: rx_ready  output  1  loader accepts a byte this cycle; a byte transfers when rx_valid & rx_ready.
REQ-008 Port: mem_we  output  1  instruction-memory write strobe.
REQ-009 Port: mem_addr  output  ADDR_W  instruction-memory word address.
REQ-010 Port: mem_wdata  output  32  instruction word to write.
REQ-011 Port: cpu_run  output  1  releases mips16_sc from stall; high only in DONE.
REQ-012 Port: load_err  output  1  the header word count exceeded DEPTH.
REQ-013 Port: word_count  output  16  header word count, as latched.

Function
REQ-014 The input stream SHALL be: a 2-byte header holding word count N (big-endian), followed by 4N bytes of instructions, each word big-endian.
REQ-015 States SHALL be HDR_HI, HDR_LO, LOAD, DONE and ERROR; the reset state is HDR_HI.
REQ-016 HDR_HI: accepting a byte latches it into word_count[15:8] and moves to HDR_LO.
REQ-017 HDR_LO: accepting a byte latches it into word_count[7:0], then branches on N:
- N == 0 -> DONE.
- N > DEPTH -> ERROR.
- otherwise -> LOAD.
REQ-018 rx_ready SHALL be 1 in HDR_HI, HDR_LO, LOAD and ERROR, and 0 in DONE.
REQ-019 LOAD: accepted bytes are shifted into a 32-bit assembler, first byte into bits [31:24]; a 2-bit byte counter wraps 3 -> 0.
REQ-020 The cycle after the 4th byte of a word is accepted: mem_we = 1 for exactly one cycle, mem_wdata = the assembled word, mem_addr = the word index.
REQ-021 The word index SHALL start at 0 and increment by 1 after each write.
REQ-022 A byte accepted in the same cycle as mem_we = 1 SHALL be assembled without loss; the loader sustains 1 byte per cycle with no bubbles.
REQ-023 Gaps in rx_valid SHALL stall assembly without corrupting partial words.
REQ-024 After the write of word N-1, the state moves to DONE in the next cycle; no extra write occurs.
REQ-025 DONE: cpu_run = 1 and mem_we = 0; the state is held until reset, and bytes presented are ignored.
REQ-026 ERROR: load_err = 1, cpu_run = 0, mem_we = 0; all bytes are accepted and discarded until reset.
REQ-027 mem_addr and mem_wdata SHALL hold their last values while mem_we = 0.

Reset
REQ-028 Reset SHALL be honoured in any state, including mid-word in LOAD, and SHALL return the state to HDR_HI.
REQ-029 Reset values SHALL be:
- rx_ready = 0 during the reset cycle, 1 in the cycle after.
- mem_we = 0, mem_addr = 0, mem_wdata = 0.
- cpu_run = 0, load_err = 0, word_count = 0.
- byte counter = 0, word index = 0.
REQ-030 A partial word in progress when reset is applied SHALL be discarded and never written.

Structure
REQ-031 mips16_pkg SHALL hold the loader state enum and the header length constant (2).
REQ-032 One sub-module, byte_word_assembler, SHALL hold the shift register and byte counter and raise word_ready; the FSM stays in instr_boot_loader.
REQ-033 mem_* SHALL connect directly to the mips16_sc instruction-register write port, and cpu_run SHALL drive its stall-release input.

Verification
REQ-034 Stream 00 02, 8C 43 00 00, 0C 00 00 05 at 1 byte per cycle -> two writes: addr 0 = 0x8C430000, addr 1 = 0x0C000005; cpu_run rises one cycle after the second write.
REQ-035 Header 00 00 -> no mem_we, DONE, cpu_run = 1 in the cycle after the 2nd byte.
REQ-036 Header 00 41 (N = 65 > DEPTH) -> load_err = 1, no writes, rx_ready stays 1 and 10 further bytes are drained, cpu_run = 0.
REQ-037 The first stream with rx_valid deasserted randomly 50% of cycles -> identical writes and addresses as REQ-034.
REQ-038 Reset asserted after 2 bytes of word 1, then stream 00 01, DE AD BE EF -> single write: addr 0 = 0xDEADBEEF, then DONE.
REQ-039 Full DEPTH load (N = 64, word i = i) -> last write at addr 63 = 0x0000003F, mem_addr never wraps to 0, cpu_run = 1.

Source files
------------

// File: rtl/mips16_pkg.sv
// Shared definitions for the instruction boot loader.
package mips16_pkg;

  // Loader sequencing: two header bytes, then the instruction payload.
  typedef enum logic [2:0] {
    HDR_HI = 3'd0,
    HDR_LO = 3'd1,
    LOAD   = 3'd2,
    DONE   = 3'd3,
    ERROR  = 3'd4
  } loader_state_e;

  // Number of bytes in the big-endian word-count header.
  localparam int HDR_LEN = 2;

endpackage

// File: rtl/byte_word_assembler.sv
// Packs a big-endian byte stream into 32-bit words. The first three bytes
// of a word are held in a shift register; the fourth is combined on the fly
// so the word is presented in the same cycle the final byte arrives.
module byte_word_assembler (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic        word_ready_o,
  output logic [31:0] word_o
);

  logic [23:0] shift_q;
  logic [1:0]  cnt_q;

  // Shift accepted bytes in MSB-first; the byte counter wraps after each word.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      shift_q <= 24'd0;
      cnt_q   <= 2'd0;
    end else if (byte_en_i) begin
      shift_q <= {shift_q[15:0], byte_i};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

  // A word completes when the fourth byte is being accepted.
  always_comb begin
    word_ready_o = byte_en_i && (cnt_q == 2'd3);
    word_o       = {shift_q, byte_i};
  end

endmodule

// File: rtl/instr_boot_loader.sv
// Boot loader: receives a word-count header and a program image over a
// valid/ready byte stream, writes it into instruction memory, then releases
// the CPU. Oversized images are rejected and the stream is drained.
module instr_boot_loader
  import mips16_pkg::*;
#(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 6
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic [15:0]       word_count
);

  loader_state_e     state_q;
  logic              rx_ready_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       mem_wdata_q;
  logic              cpu_run_q;
  logic              load_err_q;
  logic [15:0]       word_count_q;
  logic [ADDR_W:0]   word_idx_q;

  logic        accept;
  logic        all_written;
  logic        asm_en;
  logic        word_ready;
  logic [31:0] word;
  logic [15:0] header_n;

  // Handshake and progress terms derived from the registered state.
  always_comb begin
    accept      = rx_valid && rx_ready_q;
    all_written = ({{(15 - ADDR_W){1'b0}}, word_idx_q} == word_count_q);
    asm_en      = accept && (state_q == LOAD) && !all_written;
    header_n    = {word_count_q[15:8], rx_data};
  end

  byte_word_assembler u_asm (
    .clock_i      (clock),
    .reset_i      (reset),
    .byte_en_i    (asm_en),
    .byte_i       (rx_data),
    .word_ready_o (word_ready),
    .word_o       (word)
  );

  // Loader FSM; every output is registered and set from the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HDR_HI;
      rx_ready_q   <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'd0;
      cpu_run_q    <= 1'b0;
      load_err_q   <= 1'b0;
      word_count_q <= 16'd0;
      word_idx_q   <= '0;
    end else begin
      mem_we_q <= 1'b0;
      case (state_q)
        HDR_HI: begin
          rx_ready_q <= 1'b1;
          if (accept) begin
            word_count_q[15:8] <= rx_data;
            state_q            <= HDR_LO;
          end
        end
        HDR_LO: begin
          rx_ready_q <= 1'b1;
          if (accept) begin
            word_count_q[7:0] <= rx_data;
            if (header_n == 16'd0) begin
              state_q    <= DONE;
              rx_ready_q <= 1'b0;
              cpu_run_q  <= 1'b1;
            end else if (header_n > 16'(DEPTH)) begin
              state_q    <= ERROR;
              load_err_q <= 1'b1;
            end else begin
              state_q <= LOAD;
            end
          end
        end
        LOAD: begin
          if (all_written) begin
            state_q    <= DONE;
            rx_ready_q <= 1'b0;
            cpu_run_q  <= 1'b1;
          end else if (word_ready) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= word;
            mem_addr_q  <= word_idx_q[ADDR_W-1:0];
            word_idx_q  <= word_idx_q + {{ADDR_W{1'b0}}, 1'b1};
          end
        end
        DONE: begin
          rx_ready_q <= 1'b0;
          cpu_run_q  <= 1'b1;
        end
        ERROR: begin
          rx_ready_q <= 1'b1;
          load_err_q <= 1'b1;
        end
        default: begin
          state_q <= HDR_HI;
        end
      endcase
    end
  end

  // Drive ports straight from the registers.
  always_comb begin
    rx_ready   = rx_ready_q;
    mem_we     = mem_we_q;
    mem_addr   = mem_addr_q;
    mem_wdata  = mem_wdata_q;
    cpu_run    = cpu_run_q;
    load_err   = load_err_q;
    word_count = word_count_q;
  end

endmodule

// File: tb/tb_instr_boot_loader.sv
// Self-checking bench for instr_boot_loader: table of load scenarios plus a
// hand-written reset-mid-word sequence, with a write scoreboard.
module tb_instr_boot_loader;

  localparam int DEPTH  = 64;
  localparam int ADDR_W = 6;

  logic              clock;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_run;
  logic              load_err;
  logic [15:0]       word_count;

  instr_boot_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_run    (cpu_run),
    .load_err   (load_err),
    .word_count (word_count)
  );

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  typedef struct {
    string name;
    int    n;
    int    pattern;
    bit    gaps;
    int    drain;
    bit    expErr;
    bit    expRun;
  } vec_t;

  wr_t  expQ[$];
  wr_t  popped;
  vec_t vecs[7];

  int compCount = 0;
  int missCount = 0;
  int cycle = 0;
  int writesSeen = 0;
  int lastWriteCycle = -1;
  int runRiseCycle = -1;
  bit prevRun = 1'b0;
  bit gapMode = 1'b0;

  // Free-running clock.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Count rising edges so write/run timing can be compared.
  always @(posedge clock) cycle++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    compCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic failNote(input string name);
    compCount++;
    missCount++;
    $display("[TB] FAIL %s: bound expired or unexpected event", name);
  endtask

  // Program word generator for each table pattern.
  function automatic logic [31:0] wordFor(input int pattern, input int i);
    case (pattern)
      0:       return (i == 0) ? 32'h8C430000 : 32'h0C000005;
      1:       return 32'(i);
      default: return 32'hA5000000 ^ (32'(i) * 32'h01010101);
    endcase
  endfunction

  // Scoreboard: every write strobe is matched against the next expected write.
  always @(negedge clock) begin
    if (mem_we) begin
      writesSeen++;
      lastWriteCycle = cycle;
      if (expQ.size() == 0) begin
        failNote("unexpected_write");
      end else begin
        popped = expQ.pop_front();
        checkOutput("wr_addr", 32'(mem_addr), 32'(popped.addr));
        checkOutput("wr_data", mem_wdata, popped.data);
      end
    end
    if (cpu_run && !prevRun) runRiseCycle = cycle;
    prevRun = cpu_run;
  end

  // Offer one byte (optionally after random idle cycles) and wait for it to transfer.
  task automatic sendByte(input logic [7:0] b);
    int guard = 0;
    while (gapMode && ($urandom_range(0, 1) == 1)) begin
      rx_valid = 1'b0;
      @(negedge clock);
    end
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) failNote("rx_ready_timeout");
    @(negedge clock);
    rx_valid = 1'b0;
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
  endtask

  task automatic applyReset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    checkOutput("rst_rx_ready", 32'(rx_ready), 32'd0);
    checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
    checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
    checkOutput("rst_mem_wdata", mem_wdata, 32'd0);
    checkOutput("rst_cpu_run", 32'(cpu_run), 32'd0);
    checkOutput("rst_load_err", 32'(load_err), 32'd0);
    checkOutput("rst_word_count", 32'(word_count), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("rst_release_rx_ready", 32'(rx_ready), 32'd1);
  endtask

  task automatic waitSettled(input string name);
    int guard = 0;
    while (!cpu_run && !load_err && guard < 20) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 20) failNote(name);
    repeat (2) @(negedge clock);
  endtask

  // Run one table vector end to end and check the final state.
  task automatic applyStimulus(input vec_t v);
    logic [15:0] nHdr;
    logic [31:0] w;
    expQ.delete();
    writesSeen     = 0;
    lastWriteCycle = -1;
    runRiseCycle   = -1;
    gapMode        = 1'b0;
    applyReset();
    $display("[TB] vector %s", v.name);
    gapMode = v.gaps;
    nHdr = 16'(v.n);
    if (!v.expErr) begin
      for (int i = 0; i < v.n; i++) expQ.push_back({ADDR_W'(i), wordFor(v.pattern, i)});
    end
    sendByte(nHdr[15:8]);
    sendByte(nHdr[7:0]);
    if (v.n == 0) checkOutput("empty_run_next_cycle", 32'(cpu_run), 32'd1);
    if (v.expErr) begin
      checkOutput("err_flag_after_hdr", 32'(load_err), 32'd1);
      for (int i = 0; i < v.drain; i++) sendByte(8'($urandom));
      checkOutput("err_ready_after_drain", 32'(rx_ready), 32'd1);
    end else begin
      for (int i = 0; i < v.n; i++) begin
        w = wordFor(v.pattern, i);
        sendWord(w);
      end
    end
    gapMode = 1'b0;
    waitSettled({v.name, "_settle"});
    checkOutput("end_cpu_run", 32'(cpu_run), 32'(v.expRun));
    checkOutput("end_load_err", 32'(load_err), 32'(v.expErr));
    checkOutput("end_word_count", 32'(word_count), 32'(nHdr));
    checkOutput("end_writes_seen", 32'(writesSeen), v.expErr ? 32'd0 : 32'(v.n));
    checkOutput("end_queue_empty", 32'(expQ.size()), 32'd0);
    if (v.expRun && v.n > 0) begin
      checkOutput("run_latency", 32'(runRiseCycle), 32'(lastWriteCycle + 1));
      checkOutput("hold_mem_addr", 32'(mem_addr), 32'(v.n - 1));
      checkOutput("hold_mem_wdata", mem_wdata, wordFor(v.pattern, v.n - 1));
    end
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (3) @(negedge clock);
    checkOutput("stray_rx_ready", 32'(rx_ready), v.expErr ? 32'd1 : 32'd0);
    checkOutput("stray_cpu_run", 32'(cpu_run), 32'(v.expRun));
    rx_valid = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;

    vecs[0] = '{"two_words",      2,   0, 1'b0, 0,  1'b0, 1'b1};
    vecs[1] = '{"two_words_gaps", 2,   0, 1'b1, 0,  1'b0, 1'b1};
    vecs[2] = '{"empty",          0,   0, 1'b0, 0,  1'b0, 1'b1};
    vecs[3] = '{"oversize_65",    65,  0, 1'b0, 10, 1'b1, 1'b0};
    vecs[4] = '{"oversize_hi",    256, 0, 1'b0, 4,  1'b1, 1'b0};
    vecs[5] = '{"full_depth",     64,  1, 1'b0, 0,  1'b0, 1'b1};
    vecs[6] = '{"five_gaps",      5,   2, 1'b1, 0,  1'b0, 1'b1};

    for (int k = 0; k < 7; k++) applyStimulus(vecs[k]);

    // Reset in the middle of word 1 must discard the partial word.
    $display("[TB] sequence reset_mid_word");
    expQ.delete();
    writesSeen = 0;
    applyReset();
    expQ.push_back({ADDR_W'(0), 32'h8C430000});
    sendByte(8'h00);
    sendByte(8'h02);
    sendWord(32'h8C430000);
    sendByte(8'h0C);
    sendByte(8'h00);
    checkOutput("mid_first_write_done", 32'(writesSeen), 32'd1);
    writesSeen = 0;
    lastWriteCycle = -1;
    runRiseCycle = -1;
    applyReset();
    expQ.push_back({ADDR_W'(0), 32'hDEADBEEF});
    sendByte(8'h00);
    sendByte(8'h01);
    sendWord(32'hDEADBEEF);
    waitSettled("mid_settle");
    checkOutput("mid_writes_seen", 32'(writesSeen), 32'd1);
    checkOutput("mid_queue_empty", 32'(expQ.size()), 32'd0);
    checkOutput("mid_cpu_run", 32'(cpu_run), 32'd1);
    checkOutput("mid_run_latency", 32'(runRiseCycle), 32'(lastWriteCycle + 1));
    checkOutput("mid_word_count", 32'(word_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", compCount, missCount);
    $finish;
  end

endmodule
